comb_sweep_checker: RTL and testbench
=====================================

Name: comb_sweep_checker

Overview:
Hardware exhaustive-sweep checker for small combinational lab blocks. Drives every input combination of an N-input DUT in ascending binary order and holds each vector for a programmable number of cycles. Samples the DUT's single output at the end of each hold window, compares it against a golden truth-table parameter, and reports mismatch count and first failing vector. It is the parametrised, self-checking, synthesizable successor of the fixed 4-input hand-written stimulus sequence, so it can run on the board as well as in simulation.

Parameters:
N_IN, 4, number of DUT inputs (1..8); vector width.
HOLD_CYCLES, 10, cycles each vector is held (>=1).
EXPECT, 16'h0000, golden truth table, width 2**N_IN; bit v = expected output for input vector v.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
continuous  input  1  sampled with start; 1 = wrap and repeat sweeps until abort.
abort  input  1  return to IDLE next cycle; results are retained.
stim  output  N_IN  registered stimulus vector to the DUT.
dut_y  input  1  DUT output; synchronous to clk, settled within HOLD_CYCLES.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse after the last vector of a single-mode sweep.
err_count  output  N_IN+1  mismatches since the last accepted start; saturates at all-ones.
first_err_valid  output  1  at least one mismatch recorded since the last accepted start.
first_err_vec  output  N_IN  vector of the first mismatch; valid only when first_err_valid=1.

Behaviour:
- Reset (async, active-high): state=IDLE. Clears stim, busy, done, err_count, first_err_valid and first_err_vec.
- Registers: vec counter (N_IN bits), hold counter (clog2(HOLD_CYCLES)+1 bits), mode latch.
- State IDLE: busy=0, stim holds its last value.
  - start=1 moves to DRIVE.
  - On that transition: stim<=0, hold<=0, err_count<=0, first_err_valid<=0, mode<=continuous.
- State DRIVE: busy=1.
  - hold increments each cycle.
  - At hold==HOLD_CYCLES-1, dut_y is sampled in the same cycle and compared with EXPECT[stim].
  - On mismatch, err_count increments, saturating.
  - On the first mismatch of the run, first_err_valid<=1 and first_err_vec<=stim.
  - After the sample cycle: if stim != 2**N_IN-1, then stim<=stim+1 and hold<=0.
  - Else if mode=1: stim<=0, hold<=0, stay in DRIVE. Counts are not cleared.
  - Else: go to DONE.
- State DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing (start accepted at cycle 0):
  - stim=v during cycles 1+v*HOLD_CYCLES .. (v+1)*HOLD_CYCLES.
  - Last sample occurs at cycle 2**N_IN*HOLD_CYCLES.
  - done is high at cycle 2**N_IN*HOLD_CYCLES+1.
- abort:
  - Has priority over all DRIVE transitions, including a sample in the same cycle. That sample is discarded.
  - Next state is IDLE. Results are kept, done is not pulsed, stim keeps its value.
  - abort in IDLE or DONE has no effect beyond forcing IDLE.
- start while busy, or coincident with abort: ignored.
- HOLD_CYCLES=1: every DRIVE cycle is a sample cycle. Sweep length is 2**N_IN cycles.
- Saturation: err_count stays at 2**(N_IN+1)-1 once reached. This is reachable only in continuous mode.
- Reset mid-sweep: immediate return to reset values. No done pulse.

Decomposition:
- Package comb_sweep_pkg:
  - state_t enum {IDLE, DRIVE, DONE}.
  - Function clog2_safe.
  - Localparam constants for N_IN_MAX=8.
- Sub-module sweep_counter: vec plus hold counter pair.
  - Ports: clk, reset, clear, enable.
  - Outputs: vec, sample_tick, last_vec.
  - Keeps the FSM top module readable.

Test Plan:
- N_IN=4, HOLD=10, EXPECT=16'h6996; behavioural XOR4 DUT; pulse start -> busy high for 160 cycles, done pulse at cycle 161, err_count=0, first_err_valid=0.
- Same setup; DUT output forced wrong only for vector 5 -> err_count=1, first_err_vec=5, first_err_valid=1.
- DUT output = ~expected -> err_count=16, first_err_vec=0.
- abort asserted at cycle 45, during vector 4 on the sample cycle of vector 3 at cycle 40+... use a faulty-vector-2 DUT -> IDLE next cycle, no done pulse, err_count=1 retained. A subsequent start clears err_count to 0.
- reset pulsed mid-sweep at vector 7 -> all outputs 0 asynchronously. A subsequent start produces a full clean sweep.
- N_IN=2, HOLD=1, continuous=1, always-wrong DUT -> err_count reaches and holds 3'b111 after 7 samples. busy stays high until abort.

Source files
------------

// File: rtl/comb_sweep_checker_pkg.sv
// Shared types and helpers for the exhaustive-sweep checker.
package comb_sweep_pkg;

  localparam int N_IN_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceil-log2 that never returns 0, so a counter for a 1-cycle hold still has a bit.
  function automatic int clog2_safe(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/comb_sweep_checker_if.sv
// Control/result bundle between a sweep master (board logic or bench) and the checker.
interface comb_sweep_checker_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic            continuous;
  logic            abort;
  logic            dut_y;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic [N_IN:0]   err_count;
  logic            first_err_valid;
  logic [N_IN-1:0] first_err_vec;

  modport master (
    output start, continuous, abort, dut_y,
    input  stim, busy, done, err_count, first_err_valid, first_err_vec
  );

  modport slave (
    input  start, continuous, abort, dut_y,
    output stim, busy, done, err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/comb_sweep_checker_sweep_counter.sv
// Vector/hold counter pair: walks vectors upward, flagging the last cycle of each hold window.
module sweep_counter
  import comb_sweep_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [N_IN-1:0] vec,
  output logic            sample_tick,
  output logic            last_vec
);

  localparam int                HOLD_W    = clog2_safe(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [N_IN-1:0]   vec_reg;
  logic [HOLD_W-1:0] hold_reg;

  assign vec         = vec_reg;
  assign last_vec    = &vec_reg;
  assign sample_tick = enable && (hold_reg == HOLD_LAST);

  // The vector stops at all-ones; the owner restarts it with clear when wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_reg  <= '0;
      hold_reg <= '0;
    end else if (clear) begin
      vec_reg  <= '0;
      hold_reg <= '0;
    end else if (enable) begin
      if (hold_reg == HOLD_LAST) begin
        hold_reg <= '0;
        if (!last_vec) vec_reg <= vec_reg + 1'b1;
      end else begin
        hold_reg <= hold_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/comb_sweep_checker.sv
// Exhaustive truth-table sweep: drives every input vector, samples the DUT and logs mismatches.
module comb_sweep_checker
  import comb_sweep_pkg::*;
#(
  parameter int                N_IN        = 4,
  parameter int                HOLD_CYCLES = 10,
  parameter logic [2**N_IN-1:0] EXPECT     = '0
) (
  input logic                clk,
  input logic                reset,
  comb_sweep_checker_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DRIVE = DRIVE;
  localparam logic [1:0] S_DONE  = DONE;
  localparam int         N_VEC   = 1 << N_IN;

  logic [1:0]      state_reg, state_next;
  logic            mode_reg;
  logic [N_IN:0]   err_reg;
  logic            fev_valid_reg;
  logic [N_IN-1:0] fev_reg;

  logic [N_IN-1:0] vec;
  logic            sample_tick, last_vec;
  logic            accept, run, wrap, mismatch, expect_bit;
  logic [N_VEC-1:0] expect_hit;

  // Abort outranks everything in DRIVE, so it also gates the counter and the sample.
  assign accept = (state_reg == S_IDLE) && bus.start && !bus.abort;
  assign run    = (state_reg == S_DRIVE) && !bus.abort;
  assign wrap   = sample_tick && last_vec && mode_reg;

  sweep_counter #(
    .N_IN        (N_IN),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept || wrap),
    .enable      (run),
    .vec         (vec),
    .sample_tick (sample_tick),
    .last_vec    (last_vec)
  );

  // Golden bit lookup as a one-hot decode over the truth table.
  genvar gi;
  generate
    for (gi = 0; gi < N_VEC && gi < (1 << N_IN_MAX); gi++) begin : g_expect
      assign expect_hit[gi] = (vec == N_IN'(gi)) && EXPECT[gi];
    end
  endgenerate

  assign expect_bit = |expect_hit;
  assign mismatch   = sample_tick && (bus.dut_y != expect_bit);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_DRIVE;
      S_DRIVE: begin
        if (bus.abort)                               state_next = S_IDLE;
        else if (sample_tick && last_vec && !mode_reg) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      mode_reg      <= 1'b0;
      err_reg       <= '0;
      fev_valid_reg <= 1'b0;
      fev_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mode_reg      <= bus.continuous;
        err_reg       <= '0;
        fev_valid_reg <= 1'b0;
      end else if (mismatch) begin
        if (err_reg != '1) err_reg <= err_reg + 1'b1;
        if (!fev_valid_reg) begin
          fev_valid_reg <= 1'b1;
          fev_reg       <= vec;
        end
      end
    end
  end

  assign bus.stim            = vec;
  assign bus.busy            = (state_reg == S_DRIVE);
  assign bus.done            = (state_reg == S_DONE);
  assign bus.err_count       = err_reg;
  assign bus.first_err_valid = fev_valid_reg;
  assign bus.first_err_vec   = fev_reg;

endmodule

// File: tb/tb_comb_sweep_checker.sv
// Directed bench: a 4-input XOR sweep with injectable faults, plus a 2-input continuous saturation run.
module tb_comb_sweep_checker;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   a_mode   = 0;

  always #5 clk = ~clk;

  comb_sweep_checker_if #(.N_IN(4)) a_if ();
  comb_sweep_checker_if #(.N_IN(2)) b_if ();

  comb_sweep_checker #(.N_IN(4), .HOLD_CYCLES(10), .EXPECT(16'h6996)) u_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  comb_sweep_checker #(.N_IN(2), .HOLD_CYCLES(1), .EXPECT(4'h6)) u_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));

  // Behavioural DUTs: A is XOR4 with a selectable fault, B is XNOR2 (always wrong vs XOR2 table).
  logic a_fault;
  assign a_fault = (a_mode == 2) || (a_mode == 1 && a_if.stim == 4'd5) ||
                   (a_mode == 3 && a_if.stim == 4'd2);
  assign a_if.dut_y = (^a_if.stim) ^ a_fault;
  assign b_if.dut_y = ~(^b_if.stim);

  typedef struct {
    string      name;
    int         mode;
    logic [4:0] exp_err;
    logic       exp_valid;
    logic [3:0] exp_vec;
  } row_t;

  row_t rows [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Single-mode sweep on A; returns to the caller one cycle after the done pulse.
  task automatic run_a(output int bcyc, output logic stim1, output logic done_end,
                       output logic done_after);
    a_if.start = 1'b1;
    a_if.continuous = 1'b0;
    tick();
    a_if.start = 1'b0;
    stim1 = (a_if.stim == 4'd0) && a_if.busy;
    bcyc = 0;
    while (a_if.busy === 1'b1 && bcyc < 400) begin
      bcyc++;
      tick();
    end
    done_end = a_if.done;
    tick();
    done_after = a_if.done;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bcyc;
    logic stim1, done_end, done_after, any_done;

    rows[0] = '{"clean",     0, 5'd0,  1'b0, 4'd0};
    rows[1] = '{"fault_v5",  1, 5'd1,  1'b1, 4'd5};
    rows[2] = '{"inverted",  2, 5'd16, 1'b1, 4'd0};

    reset = 1'b1;
    a_if.start = 1'b0; a_if.continuous = 1'b0; a_if.abort = 1'b0;
    b_if.start = 1'b0; b_if.continuous = 1'b0; b_if.abort = 1'b0;
    ticks(3);
    chk("rst_stim", a_if.stim, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_err", a_if.err_count, 0);
    chk("rst_fev_valid", a_if.first_err_valid, 0);
    chk("rst_fev", a_if.first_err_vec, 0);
    reset = 1'b0;
    tick();

    for (int r = 0; r < 3; r++) begin
      a_mode = rows[r].mode;
      run_a(bcyc, stim1, done_end, done_after);
      chk({rows[r].name, "_stim_first"}, stim1, 1);
      chk({rows[r].name, "_busy_cycles"}, bcyc, 160);
      chk({rows[r].name, "_done_161"}, done_end, 1);
      chk({rows[r].name, "_done_once"}, done_after, 0);
      chk({rows[r].name, "_stim_hold"}, a_if.stim, 15);
      chk({rows[r].name, "_err"}, a_if.err_count, rows[r].exp_err);
      chk({rows[r].name, "_fev_valid"}, a_if.first_err_valid, rows[r].exp_valid);
      if (rows[r].exp_valid) chk({rows[r].name, "_fev"}, a_if.first_err_vec, rows[r].exp_vec);
    end

    // Abort during vector 4 with a vector-2 fault; also a start while busy that must be ignored.
    a_mode = 3;
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    ticks(19);
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    ticks(24);
    chk("abort_pre_err", a_if.err_count, 1);
    a_if.abort = 1'b1;
    tick();
    a_if.abort = 1'b0;
    chk("abort_busy", a_if.busy, 0);
    chk("abort_done", a_if.done, 0);
    chk("abort_err_kept", a_if.err_count, 1);
    chk("abort_fev_valid", a_if.first_err_valid, 1);
    chk("abort_fev", a_if.first_err_vec, 2);
    chk("abort_stim_kept", a_if.stim, 4);
    any_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_done = any_done | a_if.done;
    end
    chk("abort_no_done", any_done, 0);

    // Restart clears results; then abort exactly on vector 2's sample cycle discards it.
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    chk("restart_err", a_if.err_count, 0);
    chk("restart_fev_valid", a_if.first_err_valid, 0);
    ticks(29);
    a_if.abort = 1'b1;
    tick();
    a_if.abort = 1'b0;
    chk("abort_sample_err", a_if.err_count, 0);
    chk("abort_sample_valid", a_if.first_err_valid, 0);
    chk("abort_sample_stim", a_if.stim, 2);
    chk("abort_sample_busy", a_if.busy, 0);

    // Asynchronous reset in the middle of vector 7.
    a_mode = 2;
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    ticks(74);
    chk("mid_stim", a_if.stim, 7);
    chk("mid_err", a_if.err_count, 7);
    #2;
    reset = 1'b1;
    #1;
    chk("async_stim", a_if.stim, 0);
    chk("async_busy", a_if.busy, 0);
    chk("async_err", a_if.err_count, 0);
    chk("async_fev_valid", a_if.first_err_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    a_mode = 0;
    run_a(bcyc, stim1, done_end, done_after);
    chk("post_rst_busy_cycles", bcyc, 160);
    chk("post_rst_done", done_end, 1);
    chk("post_rst_err", a_if.err_count, 0);
    chk("post_rst_fev_valid", a_if.first_err_valid, 0);

    // Continuous 2-input, 1-cycle hold, always wrong: count saturates at 7.
    b_if.continuous = 1'b1;
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    b_if.continuous = 1'b0;
    ticks(3);
    chk("sat_err_c4", b_if.err_count, 3);
    tick();
    chk("sat_wrap_stim", b_if.stim, 0);
    chk("sat_busy_c5", b_if.busy, 1);
    ticks(3);
    chk("sat_err_c8", b_if.err_count, 7);
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      any_done = any_done | b_if.done;
    end
    chk("sat_err_hold", b_if.err_count, 7);
    chk("sat_busy_hold", b_if.busy, 1);
    chk("sat_no_done", any_done, 0);
    chk("sat_fev", b_if.first_err_vec, 0);
    b_if.abort = 1'b1;
    tick();
    b_if.abort = 1'b0;
    chk("sat_abort_busy", b_if.busy, 0);
    chk("sat_abort_err", b_if.err_count, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
